// File: rtl/biquad_pkg.sv
// Shared definitions for the biquad coefficient loader.
//   CW             : coefficient width (signed, biquad B-port format)
//   CNT_W          : width of the gap counter (enough for GAP_CYCLES up to 15)
//   GAP_CYCLES_DEF : default idle gap before the update strobe
//   state_e        : loader FSM state encoding
package biquad_pkg;

    localparam int CW             = 18;
    localparam int CNT_W          = 4;
    localparam int GAP_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_GAP    = 2'd2,
        ST_UPDATE = 2'd3
    } state_e;

endpackage

// File: rtl/biquad8_coeff_bank.sv
// Shadow coefficient store: NCOEFF x CW words, synchronous write port and
// asynchronous read port. Writes to addresses >= NCOEFF are dropped silently.
// Entries at or above NCOEFF are never written, so they always read as zero.
//   clk, rst : clock, asynchronous active-high reset (clears every word)
//   wr_en    : write strobe (already qualified by the caller)
//   wr_adr   : write address
//   wr_dat   : write data
//   rd_adr   : read address
//   rd_dat   : read data (combinational)
module biquad8_coeff_bank
    import biquad_pkg::*;
#(
    parameter int NCOEFF = 2,
    parameter int AW     = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_adr,
    input  logic [CW-1:0] wr_dat,
    input  logic [AW-1:0] rd_adr,
    output logic [CW-1:0] rd_dat
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] NCOEFF_W = NCOEFF[AW:0];

    logic [CW-1:0] bank_r [DEPTH];
    logic          wr_hit_s;

    assign wr_hit_s = wr_en && ({1'b0, wr_adr} < NCOEFF_W);

    // Shadow storage: cleared on reset, written on in-range strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_r[i] <= {CW{1'b0}};
            end
        end else if (wr_hit_s) begin
            bank_r[wr_adr] <= wr_dat;
        end
    end

    assign rd_dat = bank_r[rd_adr];

endmodule

// File: rtl/biquad8_coeff_loader.sv
// Streams a host-written shadow coefficient bank into the biquad serial
// coefficient port (highest index first), idles GAP_CYCLES cycles so the
// B1 cascade settles, then issues one update strobe.
//   clk, rst        : clock, asynchronous active-high reset
//   wr_en_i/adr/dat : host shadow-bank write port (IDLE only)
//   commit_i        : start a load sequence
//   busy_o, done_o  : sequence in progress / single-cycle completion pulse
//   err_o           : sticky, set by a write or commit while busy
//   coeff_dat_o, coeff_wr_o, coeff_update_o : biquad coefficient interface
module biquad8_coeff_loader
    import biquad_pkg::*;
#(
    parameter int NCOEFF     = 2,
    parameter int AW         = 1,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_adr_i,
    input  logic [CW-1:0] wr_dat_i,
    input  logic          commit_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [CW-1:0] coeff_dat_o,
    output logic          coeff_wr_o,
    output logic          coeff_update_o
);

    localparam int             NCOEFF_M1 = NCOEFF - 1;
    localparam int             GAP_M1    = GAP_CYCLES - 1;
    localparam logic [AW-1:0]  LAST_IDX  = NCOEFF_M1[AW-1:0];
    localparam logic [CNT_W-1:0] GAP_LAST = GAP_M1[CNT_W-1:0];

    state_e           state_r;
    logic [AW-1:0]    idx_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [CW-1:0]    dat_r;
    logic             cwr_r;
    logic             upd_r;

    logic             bank_wr_s;
    logic [AW-1:0]    rd_adr_s;
    logic [CW-1:0]    rd_dat_s;
    logic [CW-1:0]    load_dat_s;

    assign bank_wr_s = wr_en_i && (state_r == ST_IDLE);

    biquad8_coeff_bank #(
        .NCOEFF (NCOEFF),
        .AW     (AW)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (bank_wr_s),
        .wr_adr (wr_adr_i),
        .wr_dat (wr_dat_i),
        .rd_adr (rd_adr_s),
        .rd_dat (rd_dat_s)
    );

    // Read one word ahead so coeff_dat_o can be registered: the top word when
    // starting, otherwise the word below the one being presented.
    always_comb begin
        rd_adr_s = LAST_IDX;
        if (state_r == ST_IDLE) begin
            rd_adr_s = LAST_IDX;
        end else begin
            rd_adr_s = idx_r - AW'(1);
        end
    end

    // A write landing on the same edge as the commit is forwarded, so the
    // first streamed word already carries the new value.
    always_comb begin
        load_dat_s = rd_dat_s;
        if ((state_r == ST_IDLE) && wr_en_i && (wr_adr_i == LAST_IDX)) begin
            load_dat_s = wr_dat_i;
        end else begin
            load_dat_s = rd_dat_s;
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= {AW{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            dat_r   <= {CW{1'b0}};
            cwr_r   <= 1'b0;
            upd_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            upd_r  <= 1'b0;
            if ((state_r != ST_IDLE) && (commit_i || wr_en_i)) begin
                err_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (commit_i) begin
                        state_r <= ST_LOAD;
                        idx_r   <= LAST_IDX;
                        err_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        cwr_r   <= 1'b1;
                        dat_r   <= load_dat_s;
                    end
                end
                ST_LOAD: begin
                    if (idx_r == {AW{1'b0}}) begin
                        state_r <= ST_GAP;
                        cnt_r   <= GAP_LAST;
                        cwr_r   <= 1'b0;
                    end else begin
                        idx_r <= idx_r - AW'(1);
                        dat_r <= load_dat_s;
                    end
                end
                ST_GAP: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_UPDATE;
                        upd_r   <= 1'b1;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_UPDATE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cwr_r   <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o         = busy_r;
    assign done_o         = done_r;
    assign err_o          = err_r;
    assign coeff_dat_o    = dat_r;
    assign coeff_wr_o     = cwr_r;
    assign coeff_update_o = upd_r;

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Self-checking bench for biquad8_coeff_loader. Three instances cover the
// default configuration, NCOEFF=4/GAP=4, and NCOEFF=2 with AW=2; sel routes
// stimulus to one of them and picks its outputs.
module tb_biquad8_coeff_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_adr = 2'd0;
    logic [17:0] wr_dat = 18'd0;
    logic        commit = 1'b0;
    logic [1:0]  sel = 2'd0;

    logic [2:0]  busy_v, done_v, err_v, cwr_v, upd_v;
    logic [17:0] dat0, dat1, dat2;
    logic        busy, done, err, cwr, upd;
    logic [17:0] dat;

    logic [17:0] mb [3][4];
    int          n_of [3] = '{2, 4, 2};
    int          g_of [3] = '{2, 4, 2};
    logic [17:0] exp_q [$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    biquad8_coeff_loader u_dut0 (
        .clk(clk), .rst(rst), .wr_en_i(wr_en && (sel == 2'd0)), .wr_adr_i(wr_adr[0:0]),
        .wr_dat_i(wr_dat), .commit_i(commit && (sel == 2'd0)), .busy_o(busy_v[0]),
        .done_o(done_v[0]), .err_o(err_v[0]), .coeff_dat_o(dat0), .coeff_wr_o(cwr_v[0]),
        .coeff_update_o(upd_v[0])
    );

    biquad8_coeff_loader #(.NCOEFF(4), .AW(2), .GAP_CYCLES(4)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en_i(wr_en && (sel == 2'd1)), .wr_adr_i(wr_adr),
        .wr_dat_i(wr_dat), .commit_i(commit && (sel == 2'd1)), .busy_o(busy_v[1]),
        .done_o(done_v[1]), .err_o(err_v[1]), .coeff_dat_o(dat1), .coeff_wr_o(cwr_v[1]),
        .coeff_update_o(upd_v[1])
    );

    biquad8_coeff_loader #(.NCOEFF(2), .AW(2), .GAP_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .wr_en_i(wr_en && (sel == 2'd2)), .wr_adr_i(wr_adr),
        .wr_dat_i(wr_dat), .commit_i(commit && (sel == 2'd2)), .busy_o(busy_v[2]),
        .done_o(done_v[2]), .err_o(err_v[2]), .coeff_dat_o(dat2), .coeff_wr_o(cwr_v[2]),
        .coeff_update_o(upd_v[2])
    );

    // Route the selected instance's outputs to the checker.
    always_comb begin
        case (sel)
            2'd1:    begin busy = busy_v[1]; done = done_v[1]; err = err_v[1]; cwr = cwr_v[1]; upd = upd_v[1]; dat = dat1; end
            2'd2:    begin busy = busy_v[2]; done = done_v[2]; err = err_v[2]; cwr = cwr_v[2]; upd = upd_v[2]; dat = dat2; end
            default: begin busy = busy_v[0]; done = done_v[0]; err = err_v[0]; cwr = cwr_v[0]; upd = upd_v[0]; dat = dat0; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 3; s++)
            for (int a = 0; a < 4; a++)
                mb[s][a] = 18'd0;
        exp_q.delete();
    endtask

    // Host write; the model takes it only for in-range addresses.
    task automatic wr_word(input logic [1:0] a, input logic [17:0] d);
        wr_en = 1'b1; wr_adr = a; wr_dat = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (int'(a) < n_of[sel]) mb[sel][a] = d;
        @(negedge clk);
    endtask

    // Commit and check the whole sequence cycle by cycle (cycle 1 follows
    // the sampling edge). Optional same-cycle write; optional intrusions
    // (commit on cycle 2, write on cycle 3) that must only set err.
    task automatic commit_seq(input bit same_wr, input logic [1:0] sw_adr,
                              input logic [17:0] sw_dat, input bit intrude);
        int n;
        int g;
        int last;
        logic [17:0] w;
        n = n_of[sel];
        g = g_of[sel];
        last = n + g + 1;
        commit = 1'b1;
        if (same_wr) begin
            wr_en = 1'b1; wr_adr = sw_adr; wr_dat = sw_dat;
            if (int'(sw_adr) < n) mb[sel][sw_adr] = sw_dat;
        end
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(mb[sel][i]);
        for (int c = 1; c <= last + 1; c++) begin
            @(posedge clk); #1;
            commit = intrude && (c == 2);
            wr_en  = intrude && (c == 3);
            wr_adr = 2'd0;
            wr_dat = 18'h2AAAA;
            @(negedge clk);
            chk($sformatf("s%0d_wr_c%0d", sel, c), 32'(cwr), 32'(c <= n));
            chk($sformatf("s%0d_upd_c%0d", sel, c), 32'(upd), 32'(c == last));
            chk($sformatf("s%0d_done_c%0d", sel, c), 32'(done), 32'(c == last));
            chk($sformatf("s%0d_busy_c%0d", sel, c), 32'(busy), 32'(c <= last));
            if (c == 1) chk($sformatf("s%0d_err_clr", sel), 32'(err), 32'd0);
            if (c == last) chk($sformatf("s%0d_err_end", sel), 32'(err), 32'(intrude));
            if (cwr === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'(cwr), 32'd0);
                end else begin
                    w = exp_q.pop_front();
                    chk($sformatf("s%0d_dat_c%0d", sel, c), 32'(dat), 32'(w));
                end
            end
        end
        wr_en = 1'b0;
        chk("sb_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Reset asserted during the second LOAD cycle must clear everything at
    // once and never let an update pulse out.
    task automatic reset_mid_load();
        commit = 1'b1;
        @(posedge clk); #1;
        commit = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_wr", 32'(cwr), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr", 32'(cwr), 32'd0);
        chk("rst_dat", 32'(dat), 32'd0);
        chk("rst_upd", 32'(upd), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("post_rst_upd", 32'(upd), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        clear_model();
    endtask

    initial begin
        clear_model();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_done", 32'(done), 32'd0);
        chk("init_err", 32'(err), 32'd0);
        chk("init_dat", 32'(dat), 32'd0);
        chk("init_wr", 32'(cwr), 32'd0);
        chk("init_upd", 32'(upd), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Default configuration: basic load, forwarding, intrusions, reset.
        sel = 2'd0;
        wr_word(2'd0, 18'h00100);
        wr_word(2'd1, 18'h3FF00);
        commit_seq(1'b0, 2'd0, 18'd0, 1'b0);
        commit_seq(1'b1, 2'd1, 18'h12345, 1'b0);
        commit_seq(1'b0, 2'd0, 18'd0, 1'b1);
        commit_seq(1'b0, 2'd0, 18'd0, 1'b0);
        reset_mid_load();
        commit_seq(1'b0, 2'd0, 18'd0, 1'b0);

        // NCOEFF=4, GAP_CYCLES=4: update on cycle 9.
        sel = 2'd1;
        wr_word(2'd0, 18'h11111);
        wr_word(2'd1, 18'h22222);
        wr_word(2'd2, 18'h33333);
        wr_word(2'd3, 18'h04444);
        commit_seq(1'b0, 2'd0, 18'd0, 1'b0);

        // NCOEFF=2, AW=2: address 3 is silently ignored.
        sel = 2'd2;
        wr_word(2'd0, 18'h0ABCD);
        wr_word(2'd1, 18'h1F00F);
        wr_word(2'd3, 18'h3FFFF);
        chk("ign_err", 32'(err), 32'd0);
        commit_seq(1'b0, 2'd0, 18'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
